// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - MEM/WB pipeline register, load align/extend, result select and retire counter
// Stalls on outstanding loads and buffers a response that lands while the stage is frozen.
module writeback_unit #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_W,
   input  logic             flush_W,
   input  logic             Valid_M,
   input  logic             RegWrite_M,
   input  logic [1:0]       ResultSrc_M,
   input  logic [2:0]       Funct3_M,
   input  logic [4:0]       Rd_M,
   input  logic [XLEN-1:0]  ALUResult_M,
   input  logic [XLEN-1:0]  PCPlus4_M,
   input  logic [XLEN-1:0]  ImmExt_M,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic [XLEN-1:0]  Result_W,
   output logic [4:0]       Rd_W,
   output logic             RegWrite_W,
   output logic             Valid_W,
   output logic             wb_stall,
   output logic [CNT_W-1:0] instret,
   output logic             spurious_rvalid
);

   typedef enum logic [1:0] {IDLE, WAIT, HAVE_DATA} state_t;

   state_t          state, state_next;
   logic            regwrite_q;
   logic [1:0]      src_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] alu_q, pc4_q, imm_q, ld_buf;
   logic            is_load, data_ok, fire, advance, buf_load, spur_set;

   assign is_load  = Valid_W & (src_q == 2'b01);
   assign data_ok  = (state == HAVE_DATA) | mem_rvalid;
   assign fire     = Valid_W & ~stall_W & (~is_load | data_ok);
   assign wb_stall = is_load & ~data_ok;
   assign advance  = ~stall_W & ~wb_stall;

   always_comb begin
      state_next = state;
      buf_load   = 1'b0;
      spur_set   = 1'b0;
      if (is_load) begin
         case (state)
            IDLE, WAIT: begin
               if (mem_rvalid & stall_W) begin
                  buf_load   = 1'b1;
                  state_next = HAVE_DATA;
               end else if (!mem_rvalid) begin
                  state_next = WAIT;
               end
            end
            HAVE_DATA: if (mem_rvalid) spur_set = 1'b1;
            default:   state_next = IDLE;
         endcase
      end else if (mem_rvalid) begin
         spur_set = 1'b1;
      end
      if (fire) state_next = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         ld_buf          <= '0;
         spurious_rvalid <= 1'b0;
         instret         <= '0;
      end else begin
         state <= state_next;
         if (buf_load) ld_buf <= mem_rdata;
         if (spur_set) spurious_rvalid <= 1'b1;
         if (fire) instret <= instret + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Valid_W    <= 1'b0;
         regwrite_q <= 1'b0;
         src_q      <= 2'b00;
         f3_q       <= 3'b000;
         Rd_W       <= 5'd0;
         alu_q      <= '0;
         pc4_q      <= '0;
         imm_q      <= '0;
      end else if (advance) begin
         Valid_W    <= Valid_M & ~flush_W;
         regwrite_q <= RegWrite_M;
         src_q      <= ResultSrc_M;
         f3_q       <= Funct3_M;
         Rd_W       <= Rd_M;
         alu_q      <= ALUResult_M;
         pc4_q      <= PCPlus4_M;
         imm_q      <= ImmExt_M;
      end
   end

   // Lane select and extension are done at 64 bits, then truncated to XLEN.
   logic [2:0]      off, f3_eff;
   logic [XLEN-1:0] ld_src, shifted, ld_ext;
   logic [63:0]     sh64, ext64;

   always_comb begin
      off     = (XLEN == 64) ? alu_q[2:0] : {1'b0, alu_q[1:0]};
      ld_src  = (state == HAVE_DATA) ? ld_buf : mem_rdata;
      shifted = ld_src >> {off, 3'b000};
      sh64    = 64'(shifted);
      f3_eff  = f3_q;
      if (XLEN == 32 && (f3_q == 3'b011 || f3_q == 3'b110)) f3_eff = 3'b010;
      case (f3_eff)
         3'b000:  ext64 = {{56{sh64[7]}},  sh64[7:0]};
         3'b001:  ext64 = {{48{sh64[15]}}, sh64[15:0]};
         3'b010:  ext64 = {{32{sh64[31]}}, sh64[31:0]};
         3'b100:  ext64 = {56'd0, sh64[7:0]};
         3'b101:  ext64 = {48'd0, sh64[15:0]};
         3'b110:  ext64 = {32'd0, sh64[31:0]};
         default: ext64 = sh64;
      endcase
      ld_ext = ext64[XLEN-1:0];
   end

   always_comb begin
      case (src_q)
         2'b00:   Result_W = alu_q;
         2'b01:   Result_W = ld_ext;
         2'b10:   Result_W = pc4_q;
         default: Result_W = imm_q;
      endcase
   end

   assign RegWrite_W = fire & regwrite_q & (Rd_W != 5'd0);

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed and randomized checks of writeback_unit against a behavioural model
module tb_writeback_unit;
   localparam int XLEN  = 64;
   localparam int CNT_W = 64;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall_W, flush_W, Valid_M, RegWrite_M, mem_rvalid;
   logic [1:0]       ResultSrc_M;
   logic [2:0]       Funct3_M;
   logic [4:0]       Rd_M;
   logic [XLEN-1:0]  ALUResult_M, PCPlus4_M, ImmExt_M, mem_rdata;
   logic [XLEN-1:0]  Result_W;
   logic [4:0]       Rd_W;
   logic             RegWrite_W, Valid_W, wb_stall, spurious_rvalid;
   logic [CNT_W-1:0] instret;

   writeback_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall_W(stall_W), .flush_W(flush_W),
      .Valid_M(Valid_M), .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M),
      .Funct3_M(Funct3_M), .Rd_M(Rd_M), .ALUResult_M(ALUResult_M),
      .PCPlus4_M(PCPlus4_M), .ImmExt_M(ImmExt_M), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .Result_W(Result_W), .Rd_W(Rd_W),
      .RegWrite_W(RegWrite_W), .Valid_W(Valid_W), .wb_stall(wb_stall),
      .instret(instret), .spurious_rvalid(spurious_rvalid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: the instruction sitting in W, whether its load data is already in hand, counters.
   logic        m_valid, m_rw, m_have, m_spur;
   logic [1:0]  m_src;
   logic [2:0]  m_f3;
   logic [4:0]  m_rd;
   logic [63:0] m_alu, m_pc4, m_imm, m_buf, m_cnt;
   logic        e_fire, e_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] load_value(input logic [63:0] d, input logic [2:0] off,
                                              input logic [2:0] f3);
      logic [63:0] s;
      s = d >> (8 * off);
      case (f3)
         3'd0:    return 64'($signed(s[7:0]));
         3'd1:    return 64'($signed(s[15:0]));
         3'd2:    return 64'($signed(s[31:0]));
         3'd4:    return 64'(s[7:0]);
         3'd5:    return 64'(s[15:0]);
         3'd6:    return 64'(s[31:0]);
         default: return s;
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 0; m_rw = 0; m_have = 0; m_spur = 0; m_src = 0; m_f3 = 0; m_rd = 0;
      m_alu = 0; m_pc4 = 0; m_imm = 0; m_buf = 0; m_cnt = 0;
   endtask

   task automatic clr();
      stall_W = 0; flush_W = 0; Valid_M = 0; RegWrite_M = 0; ResultSrc_M = 0; Funct3_M = 0;
      Rd_M = 0; ALUResult_M = 0; PCPlus4_M = 0; ImmExt_M = 0; mem_rvalid = 0; mem_rdata = 0;
   endtask

   task automatic settle();
      logic        is_ld;
      logic [63:0] res;
      #1;
      is_ld   = m_valid && m_src == 2'b01;
      e_stall = is_ld && !(m_have || mem_rvalid);
      e_fire  = m_valid && !stall_W && !e_stall;
      case (m_src)
         2'b00:   res = m_alu;
         2'b01:   res = load_value(m_have ? m_buf : mem_rdata, m_alu[2:0], m_f3);
         2'b10:   res = m_pc4;
         default: res = m_imm;
      endcase
      chk("wb_stall",   64'(wb_stall),   64'(e_stall));
      chk("RegWrite_W", 64'(RegWrite_W), 64'(e_fire && m_rw && m_rd != 0));
      chk("Valid_W",    64'(Valid_W),    64'(m_valid));
      chk("Rd_W",       64'(Rd_W),       64'(m_rd));
      chk("Result_W",   Result_W,        res);
      chk("instret",    instret,         m_cnt);
      chk("spurious",   64'(spurious_rvalid), 64'(m_spur));
   endtask

   task automatic clock();
      logic is_ld;
      is_ld = m_valid && m_src == 2'b01;
      if (mem_rvalid && (!is_ld || m_have)) m_spur = 1;
      if (e_fire) begin
         m_cnt++;
         m_have = 0;
      end else if (is_ld && mem_rvalid && !m_have) begin
         m_have = 1;
         m_buf  = mem_rdata;
      end
      if (!stall_W && !e_stall) begin
         m_valid = Valid_M && !flush_W; m_rw = RegWrite_M; m_src = ResultSrc_M;
         m_f3 = Funct3_M; m_rd = Rd_M; m_alu = ALUResult_M; m_pc4 = PCPlus4_M; m_imm = ImmExt_M;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0] c0;
      logic        waiting;

      // Reset state
      clr(); model_reset(); rst = 1;
      @(posedge clk); #1;
      settle();
      rst = 0;
      clock();

      // ALU op
      clr(); Valid_M = 1; RegWrite_M = 1; ResultSrc_M = 2'b00; ALUResult_M = 64'h1234; Rd_M = 5;
      settle(); clock();
      clr(); settle();
      chk("alu_result", Result_W, 64'h1234);
      chk("alu_regwrite", 64'(RegWrite_W), 64'd1);
      chk("alu_rd", 64'(Rd_W), 64'd5);
      clock();
      chk("alu_instret", instret, 64'd1);

      // Same-cycle load data, LB then LBU
      for (int k = 0; k < 2; k++) begin
         clr(); Valid_M = 1; RegWrite_M = 1; ResultSrc_M = 2'b01; Rd_M = 6;
         Funct3_M = (k == 0) ? 3'b000 : 3'b100; ALUResult_M = 64'h1003;
         settle(); clock();
         clr(); mem_rvalid = 1; mem_rdata = 64'h00000000_80000000;
         settle();
         chk("lb_result", Result_W, (k == 0) ? 64'hFFFFFFFF_FFFFFF80 : 64'h80);
         chk("lb_nostall", 64'(wb_stall), 64'd0);
         clock();
      end

      // Three-cycle load latency with M fields held
      clr(); Valid_M = 1; RegWrite_M = 1; ResultSrc_M = 2'b01; Funct3_M = 3'b011;
      Rd_M = 7; ALUResult_M = 64'h2008;
      settle(); clock();
      c0 = instret;
      for (int k = 0; k < 3; k++) begin
         clr(); Valid_M = 1; RegWrite_M = 1; ALUResult_M = 64'hAAAA; Rd_M = 9;
         settle();
         chk("ld_stall", 64'(wb_stall), 64'd1);
         chk("ld_hold_rd", 64'(Rd_W), 64'd7);
         chk("ld_no_write", 64'(RegWrite_W), 64'd0);
         clock();
      end
      clr(); Valid_M = 1; RegWrite_M = 1; ALUResult_M = 64'hAAAA; Rd_M = 9;
      mem_rvalid = 1; mem_rdata = 64'h11223344_55667788;
      settle();
      chk("ld_release", 64'(wb_stall), 64'd0);
      chk("ld_write", 64'(RegWrite_W), 64'd1);
      chk("ld_result", Result_W, 64'h11223344_55667788);
      clock();
      chk("ld_instret", instret, c0 + 64'd1);

      // Response arrives while the stage is frozen
      clr(); Valid_M = 1; RegWrite_M = 1; ResultSrc_M = 2'b01; Funct3_M = 3'b010;
      Rd_M = 8; ALUResult_M = 64'h3000;
      settle(); clock();
      clr(); stall_W = 1; mem_rvalid = 1; mem_rdata = 64'hDEAD;
      settle();
      chk("frz_no_write", 64'(RegWrite_W), 64'd0);
      clock();
      clr(); stall_W = 1; settle();
      chk("frz_buffered", 64'(wb_stall), 64'd0);
      clock();
      clr(); stall_W = 1; settle(); clock();
      clr(); settle();
      chk("frz_result", Result_W, 64'hDEAD);
      chk("frz_write", 64'(RegWrite_W), 64'd1);
      clock();
      chk("frz_no_spurious", 64'(spurious_rvalid), 64'd0);

      // Flush on capture, then a write to x0
      c0 = instret;
      clr(); Valid_M = 1; RegWrite_M = 1; flush_W = 1; Rd_M = 3; ALUResult_M = 64'h77;
      settle(); clock();
      chk("flush_valid", 64'(Valid_W), 64'd0);
      clr(); Valid_M = 1; RegWrite_M = 1; Rd_M = 0; ALUResult_M = 64'h55;
      settle(); clock();
      chk("flush_instret", instret, c0);
      clr(); settle();
      chk("x0_no_write", 64'(RegWrite_W), 64'd0);
      clock();
      chk("x0_instret", instret, c0 + 64'd1);

      // Reset while a load waits
      clr(); Valid_M = 1; RegWrite_M = 1; ResultSrc_M = 2'b01; Funct3_M = 3'b011;
      Rd_M = 10; ALUResult_M = 64'h4000;
      settle(); clock();
      clr(); settle(); clock();
      rst = 1; #1;
      chk("rst_result", Result_W, 64'd0);
      chk("rst_valid", 64'(Valid_W), 64'd0);
      chk("rst_regwrite", 64'(RegWrite_W), 64'd0);
      chk("rst_rd", 64'(Rd_W), 64'd0);
      chk("rst_stall", 64'(wb_stall), 64'd0);
      chk("rst_instret", instret, 64'd0);
      model_reset();
      rst = 0;
      @(posedge clk); #1;
      clr(); Valid_M = 1; ResultSrc_M = 2'b01; Funct3_M = 3'b010; Rd_M = 11;
      settle(); clock();
      clr(); settle();
      chk("rst_idle_waits", 64'(wb_stall), 64'd1);
      mem_rvalid = 1; mem_rdata = 64'h99;
      settle(); clock();

      // Stray response with no load in W
      clr(); mem_rvalid = 1; mem_rdata = 64'h5;
      settle(); clock();
      clr(); settle();
      chk("spurious_set", 64'(spurious_rvalid), 64'd1);
      clock();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         clr();
         stall_W     = ($urandom % 5) == 0;
         flush_W     = ($urandom % 8) == 0;
         Valid_M     = ($urandom % 4) != 0;
         RegWrite_M  = 1'($urandom);
         ResultSrc_M = 2'($urandom);
         Funct3_M    = 3'($urandom % 7);
         Rd_M        = 5'($urandom);
         ALUResult_M = {$urandom, $urandom};
         PCPlus4_M   = {$urandom, $urandom};
         ImmExt_M    = {$urandom, $urandom};
         waiting     = m_valid && m_src == 2'b01 && !m_have;
         mem_rvalid  = waiting ? (($urandom % 3) == 0) : (($urandom % 40) == 0);
         mem_rdata   = {$urandom, $urandom};
         settle(); clock();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
